pipe_stall_ctrl: RTL

- Central hazard scheduler for the 5-stage RV32I pipeline.
- Merges stall requests from IF, ID (load-use) and MEM with the EX branch redirect.
- Drives the 6-bit stall vector to PC, IF_ID, ID_EX, EX_MEM and MEM_WB, plus the flush strobe to IF_ID and ID_EX.
- Registered state sequences multi-cycle memory holds and multi-bubble load-use waits, and keeps performance counters.

---
 rtl/pipe_stall_ctrl_pkg.sv | 25 ++
 rtl/pipe_stall_ctrl_if.sv | 27 ++
 rtl/pipe_stall_ctrl_sat_counter.sv | 21 ++
 rtl/pipe_stall_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline hazard scheduler: stall vectors,
// FSM encodings and stage bit positions.
package pipe_stall_ctrl_pkg;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_LU_BUBBLE = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT  = 2'd2;

    // Bubble counter holds LU_BUBBLES-1, and LU_BUBBLES is at most 7.
    localparam int BUB_W = 3;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages (master) and the
// hazard scheduler (slave).
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             rdy_in;
    logic             if_stall_req;
    logic             id_stall_req;
    logic             mem_stall_req;
    logic             mem_done;
    logic             branch_req;
    logic [5:0]       stall_out;
    logic             flush_out;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rdy_in, if_stall_req, id_stall_req, mem_stall_req, mem_done, branch_req,
        input  stall_out, flush_out, state_out, stall_cycles, flush_count
    );

    modport slave (
        input  rdy_in, if_stall_req, id_stall_req, mem_stall_req, mem_done, branch_req,
        output stall_out, flush_out, state_out, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         i_en,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard scheduler: merges stage stall requests with the EX redirect into a
// combinational stall vector and flush strobe, plus saturating perf counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    pipe_stall_ctrl_if.slave   bus
);
    localparam logic [BUB_W-1:0] LU_RELOAD = BUB_W'(LU_BUBBLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [BUB_W-1:0] r_bub_cnt;
    logic [BUB_W-1:0] w_cnt_next;
    logic [5:0]       w_stall;
    logic             w_flush;
    logic             w_stall_en;
    logic [CNT_W-1:0] w_stall_cycles;
    logic [CNT_W-1:0] w_flush_count;

    always_comb begin
        w_stall      = STALL_NONE;
        w_state_next = r_state;
        w_cnt_next   = r_bub_cnt;
        case (r_state)
            ST_RUN: begin
                w_cnt_next = '0;
                if (bus.mem_stall_req) begin
                    w_stall      = STALL_MEM;
                    w_state_next = ST_MEM_WAIT;
                end else if (bus.branch_req) begin
                    // Younger IF/ID requests belong to the wrong path.
                    w_stall = STALL_NONE;
                end else if (bus.id_stall_req) begin
                    w_stall = STALL_ID;
                    if (LU_BUBBLES > 1) begin
                        w_cnt_next   = LU_RELOAD;
                        w_state_next = ST_LU_BUBBLE;
                    end
                end else if (bus.if_stall_req) begin
                    w_stall = STALL_IF;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_done) begin
                    w_stall      = STALL_NONE;
                    w_state_next = (r_bub_cnt != '0) ? ST_LU_BUBBLE : ST_RUN;
                end else begin
                    w_stall = STALL_MEM;
                end
            end
            ST_LU_BUBBLE: begin
                if (bus.mem_stall_req) begin
                    w_stall      = STALL_MEM;
                    w_state_next = ST_MEM_WAIT;
                end else if (bus.branch_req) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_RUN;
                end else begin
                    w_stall = STALL_ID;
                    if (r_bub_cnt > BUB_W'(1)) begin
                        w_cnt_next = r_bub_cnt - BUB_W'(1);
                    end else begin
                        w_cnt_next   = '0;
                        w_state_next = ST_RUN;
                    end
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = ST_RUN;
            end
        endcase
        if (!bus.rdy_in) begin
            w_stall = STALL_ALL;
        end
        if (!rst_in) begin
            w_stall = STALL_NONE;
        end
    end

    // A branch that arrives while EX is held stays pending until the hold lifts.
    assign w_flush    = rst_in & bus.rdy_in & bus.branch_req & ~w_stall[STG_EX];
    assign w_stall_en = bus.rdy_in & w_stall[STG_PC];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= ST_RUN;
            r_bub_cnt <= '0;
        end else if (bus.rdy_in) begin
            r_state   <= w_state_next;
            r_bub_cnt <= w_cnt_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_en    (w_stall_en),
        .o_count (w_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_en    (w_flush),
        .o_count (w_flush_count)
    );

    assign bus.stall_out    = w_stall;
    assign bus.flush_out    = w_flush;
    assign bus.state_out    = r_state;
    assign bus.stall_cycles = w_stall_cycles;
    assign bus.flush_count  = w_flush_count;
endmodule
